regfile_wb_buffer: RTL and testbench
====================================

Name: regfile_wb_buffer

Overview:
Writeback buffer that sits in front of the register file's single write port. It accepts writeback requests (rd address, data) through a valid/ready handshake and queues them in an in-order FIFO. It drains one entry per cycle into the register file when the port is granted. It also gives register read ports a forwarding lookup, so that values still queued and not yet written are visible to readers.

Parameters:
N_REGS, NUM_REGS, number of architectural registers; address width AW = $clog2(N_REGS)
DEPTH, 4, number of FIFO entries; must be a power of two, at least 2
N_RPORTS, 2, number of forwarding lookup ports (one per register file read port)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_flush  in  1  discard all queued entries (trap/redirect)
i_valid  in  1  writeback request valid
o_ready  out  1  buffer can accept a request this cycle
i_addr  in  AW  destination register of the request
i_data  in  XLEN  writeback data of the request
i_drain_en  in  1  register file write port granted this cycle
o_we  out  1  register file write enable
o_waddr  out  AW  register file write address (head entry)
o_wdata  out  XLEN  register file write data (head entry)
i_fwd_addr  in  AW x N_RPORTS  lookup address per read port (unpacked [0:N_RPORTS-1])
o_fwd_hit  out  N_RPORTS  lookup matched a queued entry
o_fwd_data  out  XLEN x N_RPORTS  forwarded data per port (unpacked [0:N_RPORTS-1])
o_count  out  $clog2(DEPTH)+1  number of valid entries
o_empty  out  1  o_count == 0

Behaviour:
- Storage: circular FIFO with head pointer, tail pointer and count. Pointers are AW_D = $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Reset (i_rst at posedge): head = tail = count = 0. All entry valid bits are cleared. Entry payload is don't-care.
- Reset values of outputs: o_count = 0, o_empty = 1, o_we = 0, o_fwd_hit = 0, o_ready = 1. o_waddr, o_wdata and o_fwd_data are 0 while the buffer is empty.
- o_ready = (count < DEPTH) & ~i_flush. It does not depend on a same-cycle dequeue, so a full buffer stalls the producer for one cycle even if draining.
- Enqueue: occurs at posedge when i_valid & o_ready.
  - Request with i_addr == 0: it is accepted (handshake completes) but not stored. count and tail are unchanged.
  - Otherwise: the entry {i_addr, i_data} is written at tail, tail increments, count increments.
- Drain (combinational from head): o_we = ~empty & i_drain_en & ~i_flush. o_waddr and o_wdata are the head entry. When o_we is high, head increments at posedge and count decrements.
- Simultaneous enqueue (non-x0) and drain: count is unchanged. Both pointers advance.
- Latency: a request accepted at edge N is presented on o_we at cycle N+1 at the earliest, if the buffer was empty and i_drain_en is high.
- Flush: while i_flush is high, o_we = 0 and o_ready = 0. At posedge, head = tail = count = 0. Flush has priority over enqueue and drain. Reset has priority over flush.
- Forwarding (combinational, one per port):
  - The lookup scans the valid entries and finds the youngest (closest to tail) entry whose address equals i_fwd_addr[p].
  - Hit: o_fwd_hit[p] = 1 and o_fwd_data[p] = that entry's data.
  - Miss: 0 and 0.
  - i_fwd_addr[p] == 0 never hits.
  - The head entry being drained in the same cycle still forwards.
  - A request being enqueued in the same cycle does not forward; it becomes visible from the next cycle.
  - The consuming read mux selects o_fwd_data over the register file value on hit.
- Order: entries drain strictly in enqueue order. Multiple entries with the same address are all written, so the last value written wins in the register file.
- While empty: o_we = 0 regardless of i_drain_en.

Test Plan:
- Reset then idle: assert i_rst 2 cycles -> o_empty=1, o_count=0, o_we=0, o_ready=1, o_fwd_hit=0 for all ports.
- Single write, drain held off: enqueue x5=0xDEADBEEF with i_drain_en=0 -> o_count=1 and fwd[0] lookup x5 hits with 0xDEADBEEF. Then i_drain_en=1 -> o_we=1, o_waddr=5, o_wdata=0xDEADBEEF for exactly one cycle, then o_empty=1.
- Youngest-wins forwarding: enqueue x7=1, x7=2, x3=9 with drain off -> lookup x7 gives hit, 2; lookup x3 gives hit, 9; lookup x0 gives hit=0. Drain order is observed as (7,1), (7,2), (3,9).
- Full and wrap: with drain off, enqueue DEPTH=4 entries x1..x4 -> o_ready=0 and o_count=4. Drain 2, enqueue x10, x11 (pointers wrap) -> drain order x3, x4, x10, x11.
- x0 discard and simultaneity: enqueue x0=0x55 -> handshake completes, o_count unchanged, o_we never shows address 0. With o_count=2, enqueue x9 while draining -> o_count stays 2.
- Flush mid-operation: 3 entries queued, i_flush=1 together with i_valid=1 and i_drain_en=1 -> o_we=0 and o_ready=0 that cycle; the next cycle o_count=0 and the lookup of the flushed address misses.

Source files
------------

// File: rtl/regfile_wb_buffer.sv
// ---------------------------------------------------------------------------
// regfile_wb_buffer
//
// This is the writeback buffer in front of the register file's single write
// port. It takes writeback requests (rd, data) through a valid/ready
// handshake and holds them in an in-order circular FIFO. When the write port
// is granted, it drains one entry per cycle. It also provides a forwarding
// lookup per read port, so readers see values that are queued but not yet
// written.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_flush             discard all queued entries (trap/redirect)
//   i_valid/o_ready     writeback request handshake
//   i_addr, i_data      request destination register and data
//   i_drain_en          register file write port granted this cycle
//   o_we/o_waddr/o_wdata  register file write (head entry)
//   i_fwd_addr[p]       lookup address per read port
//   o_fwd_hit[p]        lookup matched a queued entry
//   o_fwd_data[p]       data of the youngest matching entry
//   o_count, o_empty    occupancy
// ---------------------------------------------------------------------------
module regfile_wb_buffer #(
  parameter  int N_REGS   = 32,
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 4,
  parameter  int N_RPORTS = 2,
  localparam int AW       = $clog2(N_REGS),
  localparam int AW_D     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [AW-1:0]     i_addr,
  input  logic [XLEN-1:0]   i_data,
  input  logic              i_drain_en,
  output logic              o_we,
  output logic [AW-1:0]     o_waddr,
  output logic [XLEN-1:0]   o_wdata,
  input  logic [AW-1:0]     i_fwd_addr [0:N_RPORTS-1],
  output logic [N_RPORTS-1:0] o_fwd_hit,
  output logic [XLEN-1:0]   o_fwd_data [0:N_RPORTS-1],
  output logic [AW_D:0]     o_count,
  output logic              o_empty
);

  localparam logic [AW_D:0] CNT_FULL = (AW_D + 1)'(DEPTH);

  logic [AW_D-1:0]  r_head;
  logic [AW_D-1:0]  r_tail;
  logic [AW_D:0]    r_count;
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [XLEN-1:0]  r_data [DEPTH];

  logic w_empty;
  logic w_ready;
  logic w_enq;
  logic w_deq;

  assign w_empty = (r_count == '0);
  // Ready ignores a same-cycle dequeue, which keeps the producer path short.
  assign w_ready = (r_count != CNT_FULL) & ~i_flush;
  // x0 writes complete the handshake but are never stored.
  assign w_enq   = i_valid & w_ready & (i_addr != '0);
  assign w_deq   = ~w_empty & i_drain_en & ~i_flush;

  assign o_ready = w_ready;
  assign o_we    = w_deq;
  assign o_waddr = w_empty ? '0 : r_addr[r_head];
  assign o_wdata = w_empty ? '0 : r_data[r_head];
  assign o_count = r_count;
  assign o_empty = w_empty;

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_enq) begin
        r_tail        <= r_tail + 1'b1;
        r_vld[r_tail] <= 1'b1;
      end
      if (w_deq) begin
        r_head        <= r_head + 1'b1;
        r_vld[r_head] <= 1'b0;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage is not reset; the valid bits qualify every use.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_addr[r_tail] <= i_addr;
      r_data[r_tail] <= i_data;
    end
  end

  // Forwarding: walk the entries from oldest (head) to youngest, so a later
  // match overrides an earlier one and the youngest value wins. The head
  // entry still forwards in the cycle it drains. A same-cycle enqueue is not
  // visible because it is not in storage yet.
  always_comb begin
    logic [AW_D-1:0] w_idx;
    o_fwd_hit = '0;
    for (int p = 0; p < N_RPORTS; p++) begin
      o_fwd_data[p] = '0;
    end
    for (int p = 0; p < N_RPORTS; p++) begin
      for (int k = 0; k < DEPTH; k++) begin
        w_idx = r_head + AW_D'(k);
        if (r_vld[w_idx] && (i_fwd_addr[p] != '0) && (r_addr[w_idx] == i_fwd_addr[p])) begin
          o_fwd_hit[p]  = 1'b1;
          o_fwd_data[p] = r_data[w_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
module tb_regfile_wb_buffer;

  localparam int XLEN     = 32;
  localparam int N_REGS   = 32;
  localparam int DEPTH    = 4;
  localparam int N_RPORTS = 2;
  localparam int AW       = 5;
  localparam int CW       = 3;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [AW-1:0]     i_addr;
  logic [XLEN-1:0]   i_data;
  logic              i_drain_en;
  logic              o_we;
  logic [AW-1:0]     o_waddr;
  logic [XLEN-1:0]   o_wdata;
  logic [AW-1:0]     i_fwd_addr [0:N_RPORTS-1];
  logic [N_RPORTS-1:0] o_fwd_hit;
  logic [XLEN-1:0]   o_fwd_data [0:N_RPORTS-1];
  logic [CW-1:0]     o_count;
  logic              o_empty;

  always #5 i_clk = ~i_clk;

  regfile_wb_buffer #(
    .N_REGS(N_REGS), .XLEN(XLEN), .DEPTH(DEPTH), .N_RPORTS(N_RPORTS)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_valid(i_valid), .o_ready(o_ready), .i_addr(i_addr), .i_data(i_data),
    .i_drain_en(i_drain_en), .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
    .i_fwd_addr(i_fwd_addr), .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data),
    .o_count(o_count), .o_empty(o_empty)
  );

  typedef struct packed {
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
  } ent_t;

  // Reference model: the queued writebacks in program order.
  ent_t q[$];
  // Writes actually issued by the DUT, in the order they appeared.
  ent_t dlog[$];

  int n_assert = 0;
  int n_fail   = 0;
  logic seen_x0_write = 1'b0;

  // Snapshot of the outputs at the most recent check point.
  logic            s_we, s_ready;
  logic [AW-1:0]   s_waddr;
  logic [XLEN-1:0] s_wdata;
  logic [CW-1:0]   s_count;
  logic [N_RPORTS-1:0] s_hit;
  logic [XLEN-1:0] s_fd [0:N_RPORTS-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model at the negedge, then let one
  // clock edge happen and advance the model.
  task automatic cycle();
    logic exp_ready, exp_we, eh;
    logic [XLEN-1:0] ed;
    logic [AW-1:0] ea;
    ent_t e;
    @(negedge i_clk);
    exp_ready = (q.size() < DEPTH) && !i_flush;
    exp_we    = (q.size() > 0) && i_drain_en && !i_flush;
    chk("ready", 64'(o_ready), 64'(exp_ready));
    chk("we",    64'(o_we),    64'(exp_we));
    chk("count", 64'(o_count), 64'(q.size()));
    chk("empty", 64'(o_empty), 64'(q.size() == 0));
    ea = (q.size() > 0) ? q[0].a : '0;
    ed = (q.size() > 0) ? q[0].d : '0;
    chk("waddr", 64'(o_waddr), 64'(ea));
    chk("wdata", 64'(o_wdata), 64'(ed));
    for (int p = 0; p < N_RPORTS; p++) begin
      eh = 1'b0;
      ed = '0;
      if (i_fwd_addr[p] != '0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].a == i_fwd_addr[p]) begin
            eh = 1'b1;
            ed = q[i].d;
            break;
          end
        end
      end
      chk($sformatf("fwd_hit%0d", p),  64'(o_fwd_hit[p]),  64'(eh));
      chk($sformatf("fwd_data%0d", p), 64'(o_fwd_data[p]), 64'(ed));
      s_hit[p] = o_fwd_hit[p];
      s_fd[p]  = o_fwd_data[p];
    end
    s_we = o_we; s_ready = o_ready; s_waddr = o_waddr; s_wdata = o_wdata; s_count = o_count;
    if (o_we) begin
      e.a = o_waddr; e.d = o_wdata;
      dlog.push_back(e);
      if (o_waddr == '0) seen_x0_write = 1'b1;
    end
    @(posedge i_clk);
    if (i_flush) begin
      q.delete();
    end else begin
      if (exp_we) void'(q.pop_front());
      if (i_valid && exp_ready && (i_addr != '0)) begin
        e.a = i_addr; e.d = i_data;
        q.push_back(e);
      end
    end
    #1;
  endtask

  task automatic req(input logic v, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                     input logic dr, input logic fl);
    i_valid = v; i_addr = a; i_data = d; i_drain_en = dr; i_flush = fl;
  endtask

  initial begin
    i_rst = 1'b1;
    req(1'b0, '0, '0, 1'b0, 1'b0);
    i_fwd_addr[0] = '0;
    i_fwd_addr[1] = '0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Reset state, idle
    cycle();
    chk("rst_empty", 64'(s_count), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd1);
    chk("rst_we",    64'(s_we),    64'd0);
    chk("rst_hit",   64'(s_hit),   64'd0);

    // Single write with the drain held off
    i_fwd_addr[0] = 5'd5;
    req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    cycle();
    req(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("single_count", 64'(s_count), 64'd1);
    chk("single_hit",   64'(s_hit[0]), 64'd1);
    chk("single_fd",    64'(s_fd[0]), 64'hDEADBEEF);
    i_drain_en = 1'b1;
    cycle();
    chk("single_we",    64'(s_we),    64'd1);
    chk("single_waddr", 64'(s_waddr), 64'd5);
    chk("single_wdata", 64'(s_wdata), 64'hDEADBEEF);
    cycle();
    chk("single_we_off", 64'(s_we),    64'd0);
    chk("single_empty",  64'(s_count), 64'd0);

    // The youngest matching entry is the one forwarded
    req(1'b1, 5'd7, 32'd1, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd7, 32'd2, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd3, 32'd9, 1'b0, 1'b0); cycle();
    req(1'b0, '0, '0, 1'b0, 1'b0);
    i_fwd_addr[0] = 5'd7; i_fwd_addr[1] = 5'd3;
    cycle();
    chk("yw_hit7",  64'(s_hit[0]), 64'd1);
    chk("yw_data7", 64'(s_fd[0]),  64'd2);
    chk("yw_hit3",  64'(s_hit[1]), 64'd1);
    chk("yw_data3", 64'(s_fd[1]),  64'd9);
    i_fwd_addr[0] = 5'd0;
    cycle();
    chk("yw_hit0", 64'(s_hit[0]), 64'd0);
    dlog.delete();
    i_drain_en = 1'b1;
    repeat (3) cycle();
    i_drain_en = 1'b0;
    chk("yw_nwr", 64'(dlog.size()), 64'd3);
    chk("yw_o0", 64'(dlog[0]), {27'd0, 5'd7, 32'd1});
    chk("yw_o1", 64'(dlog[1]), {27'd0, 5'd7, 32'd2});
    chk("yw_o2", 64'(dlog[2]), {27'd0, 5'd3, 32'd9});

    // Filling the buffer, then wrapping the pointers
    dlog.delete();
    for (int i = 1; i <= 4; i++) begin
      req(1'b1, AW'(i), 32'h100 + 32'(i), 1'b0, 1'b0);
      cycle();
    end
    req(1'b1, 5'd6, 32'h600, 1'b0, 1'b0);
    cycle();
    chk("full_ready", 64'(s_ready), 64'd0);
    chk("full_count", 64'(s_count), 64'd4);
    req(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) cycle();
    req(1'b1, 5'd10, 32'h10A, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd11, 32'h10B, 1'b0, 1'b0); cycle();
    req(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (4) cycle();
    i_drain_en = 1'b0;
    chk("wrap_nwr", 64'(dlog.size()), 64'd6);
    chk("wrap_a2", 64'(dlog[2].a), 64'd3);
    chk("wrap_a3", 64'(dlog[3].a), 64'd4);
    chk("wrap_a4", 64'(dlog[4]), {27'd0, 5'd10, 32'h10A});
    chk("wrap_a5", 64'(dlog[5]), {27'd0, 5'd11, 32'h10B});

    // x0 requests complete the handshake but are not queued
    req(1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
    cycle();
    chk("x0_ready", 64'(s_ready), 64'd1);
    req(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("x0_count", 64'(s_count), 64'd0);

    // Enqueue and drain in the same cycle leave the count unchanged
    req(1'b1, 5'd12, 32'hC, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd13, 32'hD, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd9,  32'h9, 1'b1, 1'b0); cycle();
    chk("sim_we", 64'(s_we), 64'd1);
    req(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("sim_count", 64'(s_count), 64'd2);
    i_drain_en = 1'b1;
    repeat (2) cycle();
    i_drain_en = 1'b0;

    // Flush while a request and a drain are also presented
    req(1'b1, 5'd20, 32'h20, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd21, 32'h21, 1'b0, 1'b0); cycle();
    req(1'b1, 5'd22, 32'h22, 1'b0, 1'b0); cycle();
    i_fwd_addr[0] = 5'd21;
    req(1'b1, 5'd23, 32'h23, 1'b1, 1'b1);
    cycle();
    chk("fl_we",    64'(s_we),    64'd0);
    chk("fl_ready", 64'(s_ready), 64'd0);
    chk("fl_hit_before", 64'(s_hit[0]), 64'd1);
    req(1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("fl_count", 64'(s_count), 64'd0);
    chk("fl_hit",   64'(s_hit[0]), 64'd0);

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      i_valid    = ($urandom_range(0, 1) == 1);
      i_addr     = AW'($urandom_range(0, 7));
      i_data     = $urandom;
      i_drain_en = ($urandom_range(0, 9) < 6);
      i_flush    = ($urandom_range(0, 39) == 0);
      i_fwd_addr[0] = AW'($urandom_range(0, 7));
      i_fwd_addr[1] = AW'($urandom_range(0, 7));
      cycle();
    end
    req(1'b0, '0, '0, 1'b0, 1'b0);

    chk("no_x0_write", 64'(seen_x0_write), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
